q_trial_sequencer: RTL and testbench

Top-level controller for Q-learning training runs on the maze.
- Starts each episode, places the agent at START_STATE, and issues one step request per move to the Q-update datapath.
- Ends the episode on reaching the goal or hitting the step limit.
- Counts episodes and stops the trial after MAX_EPISODES.
- Replaces the free-running edge-triggered episode counting with a single-clock sequencer.

---
 rtl/q_learn_pkg.sv | 16 +
 rtl/q_trial_sequencer_handshake.sv | 37 +++
 rtl/q_trial_sequencer.sv | 96 +++++++++
 tb/tb_q_trial_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/q_learn_pkg.sv
// q_learn_pkg: shared maze constants, state type and sequencer FSM encoding.
package q_learn_pkg;
  localparam int STATE_W = 6;
  localparam int NUM_STATES = 37;
  localparam int START_STATE = 0;
  localparam int GOAL_STATE = 36;
  typedef logic [STATE_W-1:0] maze_state_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_EP_INIT,
    S_STEP_REQ,
    S_STEP_WAIT,
    S_EP_END,
    S_DONE
  } state_e;
endpackage

// File: rtl/q_trial_sequencer_handshake.sv
// q_step_handshake: drives step_req, accepts step_done and tracks the agent's maze state.
module q_step_handshake
  import q_learn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        arm,
  input  logic        waiting,
  input  logic        step_done,
  input  maze_state_t next_state,
  output logic        step_req,
  output maze_state_t maze_state,
  output logic        fire,
  output logic        goal
);
  logic step_req_q, step_req_d;
  maze_state_t maze_state_q, maze_state_d;
  always_comb begin
    fire = waiting && step_done;
    // out-of-range states end the episode as if the goal were reached
    goal = (next_state == maze_state_t'(GOAL_STATE)) || (int'(next_state) >= NUM_STATES);
    step_req_d = arm ? 1'b1 : fire ? 1'b0 : step_req_q;
    maze_state_d = init ? maze_state_t'(START_STATE) : fire ? next_state : maze_state_q;
    step_req = step_req_q;
    maze_state = maze_state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      step_req_q <= 1'b0;
      maze_state_q <= maze_state_t'(START_STATE);
    end else begin
      step_req_q <= step_req_d;
      maze_state_q <= maze_state_d;
    end
  end
endmodule

// File: rtl/q_trial_sequencer.sv
// q_trial_sequencer: episode/trial sequencer issuing one Q-update step request per move.
module q_trial_sequencer
  import q_learn_pkg::*;
#(
  parameter int EP_W = 8,
  parameter int MAX_EPISODES = 200,
  parameter int STEP_W = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               step_req,
  output logic [STATE_W-1:0] maze_state,
  input  logic               step_done,
  input  logic [STATE_W-1:0] next_state,
  output logic [EP_W-1:0]    episode_count,
  output logic [STEP_W-1:0]  step_count,
  output logic               loop_start,
  output logic               ep_finish,
  output logic               ep_timeout,
  output logic               trial_stop,
  output logic               busy
);
  localparam logic [EP_W-1:0] EP_LAST = EP_W'(MAX_EPISODES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);
  state_e state_q, state_d;
  logic [EP_W-1:0] ep_q, ep_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic timeout_q, timeout_d, fire, goal, at_limit;
  q_step_handshake u_hs (
    .clk        (clk),
    .rst        (rst),
    .init       (state_q == S_EP_INIT),
    .arm        (state_q == S_STEP_REQ),
    .waiting    (state_q == S_STEP_WAIT),
    .step_done  (step_done),
    .next_state (next_state),
    .step_req   (step_req),
    .maze_state (maze_state),
    .fire       (fire),
    .goal       (goal)
  );
  always_comb begin
    state_d = state_q;
    ep_d = ep_q;
    step_d = step_q;
    timeout_d = timeout_q;
    at_limit = step_q == STEP_LAST;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = start ? S_EP_INIT : state_q;
        ep_d = start ? '0 : ep_q;
      end
      S_EP_INIT: begin
        step_d = '0;
        timeout_d = 1'b0;
        state_d = S_STEP_REQ;
      end
      S_STEP_REQ: state_d = S_STEP_WAIT;
      S_STEP_WAIT: begin
        step_d = fire ? step_q + 1'b1 : step_q;
        // a goal on the limiting step counts as a goal, not a timeout
        timeout_d = fire ? (!goal && at_limit) : timeout_q;
        state_d = !fire ? S_STEP_WAIT : (goal || at_limit) ? S_EP_END : S_STEP_REQ;
      end
      S_EP_END: begin
        ep_d = ep_q + 1'b1;
        state_d = (ep_q == EP_LAST) ? S_DONE : S_EP_INIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    episode_count = ep_q;
    step_count = step_q;
    loop_start = (state_q == S_EP_INIT) && (ep_q == '0);
    ep_finish = state_q == S_EP_END;
    ep_timeout = (state_q == S_EP_END) && timeout_q;
    trial_stop = state_q == S_DONE;
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ep_q <= '0;
      step_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ep_q <= ep_d;
      step_q <= step_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_q_trial_sequencer.sv
// tb_q_trial_sequencer: directed checks of episode stepping, limits, trial end and reset abort.
module tb_q_trial_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, step_done = 1'b0;
  logic [5:0] next_state = '0;
  logic step_req, loop_start, ep_finish, ep_timeout, trial_stop, busy;
  logic [5:0] maze_state;
  logic [7:0] episode_count, step_count;
  int n_chk = 0, n_fail = 0, n_fin = 0, n_loop = 0, base;
  q_trial_sequencer #(.MAX_EPISODES(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .step_req      (step_req),
    .maze_state    (maze_state),
    .step_done     (step_done),
    .next_state    (next_state),
    .episode_count (episode_count),
    .step_count    (step_count),
    .loop_start    (loop_start),
    .ep_finish     (ep_finish),
    .ep_timeout    (ep_timeout),
    .trial_stop    (trial_stop),
    .busy          (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ep_finish) n_fin++;
    if (loop_start) n_loop++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_step(input logic [5:0] ns, input int lat);
    int i;
    for (i = 0; i < 50 && !step_req; i++) tick();
    if (!step_req) chk("step_req_timeout", 0, 1);
    repeat (lat - 1) @(posedge clk);
    #1;
    step_done = 1'b1;
    next_state = ns;
    tick();
    step_done = 1'b0;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_step_req", step_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trial_stop", trial_stop, 0);
    chk("rst_maze", maze_state, 0);
    chk("rst_ep_cnt", episode_count, 0);
    chk("rst_step_cnt", step_count, 0);
    chk("rst_pulses", {loop_start, ep_finish, ep_timeout}, 0);
    rst = 1'b0;
    start = 1'b1;
    tick();
    chk("init_loop_start", loop_start, 1);
    step_done = 1'b1;
    next_state = 6'd9;
    tick();
    chk("stepreq_req_low", step_req, 0);
    chk("stepreq_maze", maze_state, 0);
    chk("stepreq_busy", busy, 1);
    tick();
    chk("wait_req_high", step_req, 1);
    chk("spurious_step_cnt", step_count, 0);
    chk("spurious_maze", maze_state, 0);
    step_done = 1'b0;
    start = 1'b0;
    do_step(6'd1, 3);
    chk("ep1_maze1", maze_state, 1);
    chk("ep1_step1", step_count, 1);
    do_step(6'd2, 3);
    chk("ep1_maze2", maze_state, 2);
    do_step(6'd36, 3);
    chk("ep1_maze36", maze_state, 36);
    chk("ep1_step3", step_count, 3);
    chk("ep1_finish", ep_finish, 1);
    chk("ep1_timeout", ep_timeout, 0);
    tick();
    chk("ep1_ep_cnt", episode_count, 1);
    chk("ep1_fin_count", n_fin, 1);
    chk("ep1_loop_once", n_loop, 1);
    chk("ep2_no_loop_start", loop_start, 0);
    for (int i = 1; i <= 255; i++) begin
      do_step(6'd5, 1);
      if (i == 254) chk("ep2_pre_limit", ep_finish, 0);
    end
    chk("ep2_step255", step_count, 255);
    chk("ep2_finish", ep_finish, 1);
    chk("ep2_timeout", ep_timeout, 1);
    tick();
    chk("ep2_ep_cnt", episode_count, 2);
    tick();
    chk("ep3_maze_start", maze_state, 0);
    chk("ep3_step_clr", step_count, 0);
    do_step(6'd40, 1);
    chk("inv_finish", ep_finish, 1);
    chk("inv_timeout", ep_timeout, 0);
    chk("inv_step1", step_count, 1);
    tick();
    chk("done_trial_stop", trial_stop, 1);
    chk("done_busy", busy, 0);
    chk("done_ep_cnt", episode_count, 3);
    chk("done_fin_count", n_fin, 3);
    step_done = 1'b1;
    next_state = 6'd36;
    repeat (2) tick();
    step_done = 1'b0;
    chk("done_hold_ep", episode_count, 3);
    chk("done_hold_step", step_count, 1);
    chk("done_hold_stop", trial_stop, 1);
    base = n_fin;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_ep_clr", episode_count, 0);
    chk("restart_loop_start", loop_start, 1);
    for (int e = 0; e < 3; e++) begin
      do_step(6'd36, 1);
      chk("one_step_finish", ep_finish, 1);
      tick();
    end
    chk("t3_fin_count", n_fin - base, 3);
    chk("t3_trial_stop", trial_stop, 1);
    chk("t3_busy", busy, 0);
    chk("t3_ep_cnt", episode_count, 3);
    chk("t3_loop_count", n_loop, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) do_step(6'd5, 1);
    chk("abort_step9", step_count, 9);
    for (int i = 0; i < 50 && !step_req; i++) tick();
    chk("abort_in_wait", step_req, 1);
    base = n_fin;
    rst = 1'b1;
    tick();
    chk("abort_step_req", step_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_step_cnt", step_count, 0);
    chk("abort_ep_cnt", episode_count, 0);
    chk("abort_maze", maze_state, 0);
    rst = 1'b0;
    tick();
    chk("abort_no_finish", n_fin - base, 0);
    chk("abort_idle", {busy, trial_stop}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
